// File: rtl/low_pass_inverse_if.sv
// Ready/valid bundle for low_pass_inverse: sum samples in, recovered samples out.
// The design side uses the slave modport and the producer/consumer side uses the master modport.
interface low_pass_inverse_if #(
    parameter int width_p = 8
);
    logic [width_p:0]   data_i;
    logic               valid_i;
    logic               ready_o;
    logic [width_p-1:0] data_o;
    logic               sof_o;
    logic               valid_o;
    logic               ready_i;
    logic               error_o;

    modport slave (
        input  data_i, valid_i, ready_i,
        output ready_o, data_o, sof_o, valid_o, error_o
    );

    modport master (
        output data_i, valid_i, ready_i,
        input  ready_o, data_o, sof_o, valid_o, error_o
    );
endinterface

// File: rtl/low_pass_inverse.sv
// Inverse of the two-tap low-pass stage: x[n] = y[n] - x[n-1], history cleared every frame_len_p samples.
// Define LOW_PASS_INVERSE_SAT_EN to clamp out-of-range results and raise a sticky error_o; otherwise results wrap.
module low_pass_inverse #(
    parameter int width_p     = 8,
    parameter int frame_len_p = 256
) (
    input  logic              clk_i,
    input  logic              reset_i,
    low_pass_inverse_if.slave bus
);
    localparam int cnt_w_lp = (frame_len_p > 1) ? $clog2(frame_len_p) : 1;
    localparam logic [cnt_w_lp-1:0] cnt_last_lp =
        (frame_len_p > 1) ? cnt_w_lp'(frame_len_p - 1) : '0;

    typedef struct packed {
        logic               sof;
        logic [width_p-1:0] data;
    } entry_t;

    entry_t                mem_q [0:1];
    entry_t                mem_d [0:1];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic [width_p-1:0]    prev_q, prev_d;
    logic [cnt_w_lp-1:0]   cnt_q, cnt_d;
    logic                  started_q, started_d;

    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  is_first;
    logic [width_p-1:0]    prev_eff;
    logic signed [width_p+1:0] diff;
    logic [width_p-1:0]    result;

    // ready_o depends only on registered occupancy, never on ready_i.
    assign full        = (count_q == 2'd2);
    assign bus.ready_o = !full && !reset_i;
    assign bus.valid_o = (count_q != 2'd0);
    assign bus.data_o  = mem_q[rd_ptr_q].data;
    assign bus.sof_o   = mem_q[rd_ptr_q].sof;

    assign push = bus.valid_i && bus.ready_o;
    assign pop  = bus.valid_o && bus.ready_i;

    always_comb begin
        // NOTE: every signal written here is assigned on all paths, so no latch is inferred.
        is_first = (frame_len_p == 0) ? !started_q : (cnt_q == '0);
        prev_eff = is_first ? '0 : prev_q;
        diff     = signed'({1'b0, bus.data_i}) - signed'({2'b00, prev_eff});
    end

`ifdef LOW_PASS_INVERSE_SAT_EN
    logic error_q, error_d;
    logic out_of_range;

    always_comb begin
        out_of_range = diff[width_p+1] || diff[width_p];
        if (diff[width_p+1]) begin
            result = '0;
        end else if (diff[width_p]) begin
            result = '1;
        end else begin
            result = diff[width_p-1:0];
        end
        error_d = error_q || (push && out_of_range);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign bus.error_o = error_q;
`else
    logic unused_diff_msbs;

    assign result           = diff[width_p-1:0];
    assign unused_diff_msbs = ^diff[width_p+1:width_p];
    assign bus.error_o      = 1'b0;
`endif

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        prev_d    = prev_q;
        cnt_d     = cnt_q;
        started_d = started_q;

        if (push) begin
            mem_d[wr_ptr_q] = '{sof: is_first, data: result};
            wr_ptr_d        = !wr_ptr_q;
            prev_d          = result;
            started_d       = 1'b1;
            // With frame_len_p == 0 the counter never moves; started_q alone marks the first sample.
            if (frame_len_p != 0) begin
                cnt_d = (cnt_q == cnt_last_lp) ? '0 : cnt_q + 1'b1;
            end
        end

        if (pop) begin
            rd_ptr_d = !rd_ptr_q;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            // NOTE: the two buffer entries are reset so data_o/sof_o read 0 out of reset; a RAM-sized buffer would be left unreset.
            mem_q     <= '{default: '0};
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            prev_q    <= '0;
            cnt_q     <= '0;
            started_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            started_q <= started_d;
        end
    end
endmodule

// File: tb/tb_low_pass_inverse.sv
// Randomized and directed bench for low_pass_inverse: two instances (frame_len_p 4 and 0) share stimulus
// and are checked against an arithmetic reference model with a queue standing in for the output buffer.
module tb_low_pass_inverse;
    localparam int W   = 8;
    localparam int MAX = (1 << W) - 1;

    logic clk     = 1'b0;
    logic reset_i = 1'b1;
    always #5 clk = ~clk;

    low_pass_inverse_if #(.width_p(W)) if4 ();
    low_pass_inverse_if #(.width_p(W)) if0 ();

    low_pass_inverse #(.width_p(W), .frame_len_p(4)) dut4 (
        .clk_i  (clk),
        .reset_i(reset_i),
        .bus    (if4.slave)
    );

    low_pass_inverse #(.width_p(W), .frame_len_p(0)) dut0 (
        .clk_i  (clk),
        .reset_i(reset_i),
        .bus    (if0.slave)
    );

    // Index 0 is the frame_len_p=4 instance, index 1 the frame_len_p=0 instance.
    logic [1:0]   rdy, vld, sof, err;
    logic [W-1:0] dat [2];
    assign rdy    = {if0.ready_o, if4.ready_o};
    assign vld    = {if0.valid_o, if4.valid_o};
    assign sof    = {if0.sof_o,   if4.sof_o};
    assign err    = {if0.error_o, if4.error_o};
    assign dat[0] = if4.data_o;
    assign dat[1] = if0.data_o;

    typedef struct packed {
        logic [1:0]        sof;
        logic [1:0][W-1:0] data;
    } exp_t;

    exp_t q[$];
    int   prev_m [2];
    bit   err_m  [2];
    int   n_acc;
    int   n_pass   = 0;
    int   n_checks = 0;

    function automatic int frame_len(input int k);
        return (k == 0) ? 4 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic drive(input bit v, input int d, input bit r);
        if4.valid_i = v;  if0.valid_i = v;
        if4.data_i  = d[W:0];  if0.data_i = d[W:0];
        if4.ready_i = r;  if0.ready_i = r;
    endtask

    task automatic model_clear();
        q.delete();
        n_acc = 0;
        for (int k = 0; k < 2; k++) begin
            prev_m[k] = 0;
            err_m[k]  = 1'b0;
        end
    endtask

    // One cycle: drive at negedge, compare pre-edge outputs, then advance the model for the coming edge.
    task automatic step(input bit v, input int d, input bit r, output bit acc);
        exp_t e;
        exp_t dropped;
        int   p, dd, x, fl;
        bit   first;
        @(negedge clk);
        drive(v, d, r);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("ready%0d", k), rdy[k], q.size() < 2);
            check($sformatf("valid%0d", k), vld[k], q.size() > 0);
            check($sformatf("error%0d", k), err[k], err_m[k]);
            if (q.size() > 0) begin
                check($sformatf("data%0d", k), dat[k], q[0].data[k]);
                check($sformatf("sof%0d", k),  sof[k], q[0].sof[k]);
            end
        end
        acc = v && (q.size() < 2);
        if (r && q.size() > 0) dropped = q.pop_front();
        if (acc) begin
            for (int k = 0; k < 2; k++) begin
                fl    = frame_len(k);
                first = (fl == 0) ? (n_acc == 0) : (n_acc % fl == 0);
                p     = first ? 0 : prev_m[k];
                dd    = d - p;
`ifdef LOW_PASS_INVERSE_SAT_EN
                x = (dd < 0) ? 0 : ((dd > MAX) ? MAX : dd);
                if (dd < 0 || dd > MAX) err_m[k] = 1'b1;
`else
                x = dd & MAX;
`endif
                prev_m[k]    = x;
                e.sof[k]     = first;
                e.data[k]    = x[W-1:0];
            end
            q.push_back(e);
            n_acc++;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 reset_i = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_valid%0d", k), vld[k], 0);
            check($sformatf("rst_ready%0d", k), rdy[k], 0);
            check($sformatf("rst_data%0d", k),  dat[k], 0);
            check($sformatf("rst_sof%0d", k),   sof[k], 0);
            check($sformatf("rst_error%0d", k), err[k], 0);
        end
        drive(0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        #2 reset_i = 1'b0;
        model_clear();
    endtask

    initial begin
        bit acc;
        int idx, cyc;
        int bp [4]  = '{20, 50, 60, 40};
        int fw [8]  = '{5, 10, 10, 10, 5, 10, 10, 10};

        drive(0, 0, 0);
        model_clear();
        repeat (2) @(posedge clk);
        apply_reset();

        // Basic reconstruction: 10, 30, 50 -> 10, 20, 30.
        step(1, 10, 1, acc);
        step(1, 30, 1, acc);
        step(1, 50, 1, acc);
        repeat (3) step(0, 0, 1, acc);

        // Backpressure: four offered with ready_i low, then drained.
        apply_reset();
        idx = 0;
        cyc = 0;
        while (idx < 4 && cyc < 20) begin
            step(1, bp[idx], cyc >= 4, acc);
            if (acc) idx++;
            cyc++;
        end
        check("bp_all_accepted", idx, 4);
        repeat (4) step(0, 0, 1, acc);

        // Frame wrap on the frame_len_p=4 instance.
        apply_reset();
        foreach (fw[i]) step(1, fw[i], 1, acc);
        repeat (3) step(0, 0, 1, acc);

        // Range error: 10 then 5.
        apply_reset();
        step(1, 10, 1, acc);
        step(1, 5, 1, acc);
        @(posedge clk);
        #1;
`ifdef LOW_PASS_INVERSE_SAT_EN
        check("neg_data", if4.data_o, 0);
        check("neg_error", if4.error_o, 1);
`else
        check("neg_data", if4.data_o, 251);
        check("neg_error", if4.error_o, 0);
`endif
        repeat (3) step(0, 0, 1, acc);

        // Overflow: first sample 300.
        apply_reset();
        step(1, 300, 1, acc);
        @(posedge clk);
        #1;
`ifdef LOW_PASS_INVERSE_SAT_EN
        check("ovf_data", if0.data_o, 255);
        check("ovf_error", if0.error_o, 1);
`else
        check("ovf_data", if0.data_o, 44);
        check("ovf_error", if0.error_o, 0);
`endif
        repeat (2) step(0, 0, 1, acc);

        // Reset with two samples buffered, then a fresh 7.
        apply_reset();
        step(1, 3, 0, acc);
        step(1, 9, 0, acc);
        step(0, 0, 0, acc);
        apply_reset();
        step(1, 7, 1, acc);
        @(posedge clk);
        #1;
        check("post_rst_data", if4.data_o, 7);
        check("post_rst_sof",  if4.sof_o, 1);
        step(0, 0, 1, acc);

        // Randomized traffic with occasional asynchronous resets.
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) apply_reset();
            step($urandom_range(0, 3) != 0,
                 ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 300)) : int'($urandom_range(0, 511)),
                 $urandom_range(0, 2) != 0, acc);
        end
        repeat (3) step(0, 0, 1, acc);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/low_pass_inverse.md
# low_pass_inverse

Reconstructs the original sample stream from the two-tap sum stream produced by the low-pass stage (y[n] = x[n] + x[n-1]), using x[n] = y[n] - x[n-1]. It sits on the receive side of the audio path. It takes ready/valid sum samples and emits recovered samples through a 2-entry output buffer. History clears at fixed frame boundaries, so a corrupted sample cannot propagate indefinitely.

## Interface
- `width_p`, default 8: width of a recovered sample.
- `frame_len_p`, default 256: samples per frame before history clears. Value 0 disables frame resync. Legal values are 0 or ≥ 2.
- `clk_i` input, 1 bit: the single clock.
- `reset_i` input, 1 bit: asynchronous, active-high reset.
- `data_i` input, `width_p+1` bits: unsigned sum sample y[n].
- `valid_i` input, 1 bit: `data_i` is valid.
- `ready_o` output, 1 bit: the block can accept `data_i`.
- `data_o` output, `width_p` bits: recovered sample x[n].
- `sof_o` output, 1 bit: `data_o` is the first sample of a frame.
- `valid_o` output, 1 bit: `data_o` and `sof_o` are valid.
- `ready_i` input, 1 bit: downstream accepts `data_o`.
- `error_o` output, 1 bit: sticky range-error flag. The port is always present.

## Operation
- **Accept.** A sample is accepted when `valid_i && ready_o`.
- **Reconstruct.** Compute `d = data_i - prev` in signed `width_p+2` bits, with `prev` zero-extended.
- **History.** `prev` holds the last recovered sample. On accept it loads the value written to the buffer.
- **Frame counter.** The counter `cnt` has range 0..`frame_len_p`-1 and increments on each accept.
  - A sample accepted with `cnt==0` is written with `sof=1` and computed with `prev` treated as 0.
  - On an accept with `cnt==frame_len_p-1`, the counter wraps to 0.
  - The matching sum encoder must clear its history at the same sample boundary.
- **No resync.** With `frame_len_p==0`, only the first sample after reset has `sof=1`, and the counter stays frozen after that sample.
- **Range handling.** A result is in range when `0 ≤ d ≤ 2^width_p-1`. The out-of-range behaviour is set by Configuration.
- **Output buffer.** The buffer is a 2-entry FIFO of `{sof, data}`.
  - `ready_o = !full`.
  - `valid_o = !empty`.
  - The head entry drives `data_o` and `sof_o`.
- **Simultaneous push and pop when full.** `ready_o` is computed from the registered full flag, so no push occurs and there is no combinational path from `ready_i` to `ready_o`.
- **Simultaneous push and pop when 1 entry is held.** Occupancy stays at 1.
- **Output hold.** While `valid_o && !ready_i`, `data_o` and `sof_o` hold stable.
- **Reset values.** `reset_i` asserted at any time, including mid-frame or with the buffer full, takes effect immediately:
  - `valid_o=0`, `ready_o=0` while reset is held, then 1 on the first cycle after release.
  - `data_o=0`, `sof_o=0`, `error_o=0`.
  - `prev=0`, `cnt=0`, buffer empty.
  - Buffered samples are discarded.

## Timing
- **Latency.** A sample accepted at edge N appears on `data_o` after edge N, one cycle of latency, when the buffer was empty.
- **Throughput.** One sample per cycle while `ready_i=1`.
- **Backpressure.** With `ready_i=0`, two samples are accepted, then `ready_o` falls on the following cycle. It rises one cycle after the first pop.
- **Error timing.** `error_o` asserts on the edge that accepts the offending sample and stays high until reset.

## Configuration
- Macro: `LOW_PASS_INVERSE_SAT_EN`.
- **Defined:**
  - An out-of-range `d` is clamped: negative values become 0, and values above the maximum become 2^`width_p`-1.
  - The clamped value goes to the buffer and to `prev`.
  - `error_o` is set (sticky).
- **Undefined:**
  - The low `width_p` bits of `d` are used (modulo wrap).
  - `error_o` is tied to 0.

## Test plan
- **Basic reconstruction.** `width_p=8`, `ready_i=1`, input 10, 30, 50 → `data_o` 10, 20, 30; `sof_o` is 1 only on the first sample; each output appears 1 cycle after its accept.
- **Backpressure.** `ready_i=0`, stream 4 samples → only 2 are accepted and `ready_o=0` with `valid_o=1`. Then `ready_i=1` → the remaining samples drain in order with no loss or duplication.
- **Frame wrap.** `frame_len_p=4`, input 8 samples of y=2x for x=5 (inputs 5, 10, 10, 10, 5, 10, 10, 10) → all outputs are 5, and `sof_o=1` on output 0 and output 4.
- **Range error.** Input 10, then 5 (d=-5):
  - With `LOW_PASS_INVERSE_SAT_EN`: output 0, `error_o=1` and held.
  - Without it: output 251, `error_o=0`.
- **Overflow.** Input 300 first (d=300):
  - With the macro: output 255, `error_o=1`.
  - Without it: output 44.
- **Reset mid-operation.** Assert `reset_i` asynchronously between edges with 2 samples buffered → `valid_o=0` immediately. After release, input 7 → output 7 with `sof_o=1`.
